// File: rtl/trade_pkg.sv
// trade_pkg: shared types and sizing helpers for the order sequencing controller.
//   ctrl_state_t : FSM state encoding (WARMUP=0, IDLE=1, ISSUE=2, COOLDOWN=3)
//   order_side_t : order direction (SIDE_BUY=0, SIDE_SELL=1)
//   pos_width()  : width of the signed net-position register
//   cnt_width()  : width of a counter holding 0..n-1 (at least 1 bit)
package trade_pkg;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    IDLE     = 2'd1,
    ISSUE    = 2'd2,
    COOLDOWN = 2'd3
  } ctrl_state_t;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } order_side_t;

  // Two extra bits: one for the sign, one so +MAX_POSITION is representable
  // when MAX_POSITION is a power of two.
  function automatic int pos_width(input int max_position);
    return $clog2(max_position) + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trade_cooldown_timer.sv
// trade_cooldown_timer: loadable up/down counter with a terminal-count flag.
//   Parameters: W (counter width), COUNT_UP (1 = increment, 0 = decrement),
//               TERMINAL (value at which done is asserted).
//   Ports: clk, rst_n (async active-low, clears count to 0),
//          load / load_value (synchronous load, has priority over tick),
//          tick (advance one step), done (count == TERMINAL).
module trade_cooldown_timer #(
  parameter int             W        = 4,
  parameter bit             COUNT_UP = 1'b0,
  parameter logic [W-1:0]   TERMINAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         done
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (tick) begin
      count_reg <= COUNT_UP ? (count_reg + ONE) : (count_reg - ONE);
    end
  end

  assign done = (count_reg == TERMINAL);

endmodule

// File: rtl/trade_order_ctrl.sv
// trade_order_ctrl: sequences Z-score buy/sell decisions into single
// outstanding orders over a valid/ready handshake, with a warm-up phase,
// a signed position limit and a post-order cooldown.
//   Inputs : clk, rst_n (async active-low), enable, data_valid_z,
//            buy_signal, sell_signal, current_data, order_ready
//   Outputs: order_valid, order_side (0 buy / 1 sell), order_price,
//            position (signed net filled lots), ctrl_state
//   Build option TRADE_STATS_EN adds orders_issued, signals_dropped and
//   conflict_count counters (wrap on overflow, reset to 0).
module trade_order_ctrl
  import trade_pkg::*;
#(
  parameter int  data_width      = 16,
  parameter int  MAX_POSITION    = 8,
  parameter int  COOLDOWN_CYCLES = 16,
  parameter int  WARMUP_SAMPLES  = 32,
  localparam int PW              = pos_width(MAX_POSITION)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  data_valid_z,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [data_width-1:0] current_data,
  output logic                  order_valid,
  input  logic                  order_ready,
  output logic                  order_side,
  output logic [data_width-1:0] order_price,
  output logic signed [PW-1:0]  position,
  output logic [1:0]            ctrl_state
`ifdef TRADE_STATS_EN
  ,
  output logic [31:0]           orders_issued,
  output logic [31:0]           signals_dropped,
  output logic [15:0]           conflict_count
`endif
);

  localparam int WW = cnt_width(WARMUP_SAMPLES);
  localparam int CW = cnt_width(COOLDOWN_CYCLES);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_SAMPLES - 1);
  localparam logic [CW-1:0] CD_LOAD   = CW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic signed [PW-1:0] POS_MAX = PW'(MAX_POSITION);
  localparam logic signed [PW-1:0] POS_MIN = PW'(-MAX_POSITION);
  localparam logic signed [PW-1:0] POS_ONE = PW'(1);

  ctrl_state_t state_reg;
  order_side_t side_reg;

  logic buy_ok, sell_ok, accept, handshake;
  logic warm_done, cd_done;

  // Exactly one direction must be asserted and the limit must leave room.
  assign buy_ok    = buy_signal && !sell_signal && (position < POS_MAX);
  assign sell_ok   = sell_signal && !buy_signal && (position > POS_MIN);
  assign accept    = (state_reg == IDLE) && data_valid_z && enable && (buy_ok || sell_ok);
  // order_valid is only ever high in ISSUE, so no state qualifier is needed.
  assign handshake = order_valid && order_ready;

  // Warm-up counts qualified samples up to WARMUP_SAMPLES-1; the pulse that
  // arrives while done is set is the last warm-up sample.
  trade_cooldown_timer #(
    .W        (WW),
    .COUNT_UP (1'b1),
    .TERMINAL (WARM_LAST)
  ) u_warmup (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (1'b0),
    .load_value ('0),
    .tick       ((state_reg == WARMUP) && data_valid_z && !warm_done),
    .done       (warm_done)
  );

  // Loaded on the handshake so the count is ready on the first COOLDOWN cycle.
  trade_cooldown_timer #(
    .W        (CW),
    .COUNT_UP (1'b0),
    .TERMINAL ('0)
  ) u_cooldown (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (handshake),
    .load_value (CD_LOAD),
    .tick       ((state_reg == COOLDOWN) && !cd_done),
    .done       (cd_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WARMUP;
      order_valid <= 1'b0;
      side_reg    <= SIDE_BUY;
      order_price <= '0;
      position    <= '0;
    end else begin
      case (state_reg)
        WARMUP: begin
          if (data_valid_z && warm_done) state_reg <= IDLE;
        end
        IDLE: begin
          if (accept) begin
            order_valid <= 1'b1;
            side_reg    <= sell_ok ? SIDE_SELL : SIDE_BUY;
            order_price <= current_data;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            order_valid <= 1'b0;
            position    <= (side_reg == SIDE_SELL) ? (position - POS_ONE) : (position + POS_ONE);
            state_reg   <= (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cd_done) state_reg <= IDLE;
        end
        default: state_reg <= WARMUP;
      endcase
    end
  end

  assign order_side = side_reg;
  assign ctrl_state = state_reg;

`ifdef TRADE_STATS_EN
  logic sig_present, conflict;
  assign sig_present = data_valid_z && (buy_signal || sell_signal) && (state_reg != WARMUP);
  assign conflict    = data_valid_z && buy_signal && sell_signal && (state_reg != WARMUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orders_issued   <= '0;
      signals_dropped <= '0;
      conflict_count  <= '0;
    end else begin
      if (handshake)             orders_issued   <= orders_issued + 32'd1;
      if (sig_present && !accept) signals_dropped <= signals_dropped + 32'd1;
      if (conflict)              conflict_count  <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Bench for trade_order_ctrl. Instance A: WARMUP_SAMPLES=4, MAX_POSITION=2,
// COOLDOWN_CYCLES=16. Instance B: WARMUP_SAMPLES=1, MAX_POSITION=8,
// COOLDOWN_CYCLES=0. Each instance is held in reset while the other runs.
module tb_trade_order_ctrl;
  import trade_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_b, enable, dv, buy, sell, ready;
  logic [15:0] price;

  logic               a_valid, a_side, b_valid, b_side;
  logic [15:0]        a_price, b_price;
  logic signed [2:0]  a_pos;
  logic signed [4:0]  b_pos;
  logic [1:0]         a_state, b_state;
`ifdef TRADE_STATS_EN
  logic [31:0] a_issued, a_dropped, b_issued, b_dropped;
  logic [15:0] a_conflict, b_conflict;
`endif

  trade_order_ctrl #(.data_width(16), .MAX_POSITION(2), .COOLDOWN_CYCLES(16), .WARMUP_SAMPLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_valid_z(dv),
    .buy_signal(buy), .sell_signal(sell), .current_data(price),
    .order_valid(a_valid), .order_ready(ready), .order_side(a_side),
    .order_price(a_price), .position(a_pos), .ctrl_state(a_state)
`ifdef TRADE_STATS_EN
    , .orders_issued(a_issued), .signals_dropped(a_dropped), .conflict_count(a_conflict)
`endif
  );

  trade_order_ctrl #(.data_width(16), .MAX_POSITION(8), .COOLDOWN_CYCLES(0), .WARMUP_SAMPLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(enable), .data_valid_z(dv),
    .buy_signal(buy), .sell_signal(sell), .current_data(price),
    .order_valid(b_valid), .order_ready(ready), .order_side(b_side),
    .order_price(b_price), .position(b_pos), .ctrl_state(b_state)
`ifdef TRADE_STATS_EN
    , .orders_issued(b_issued), .signals_dropped(b_dropped), .conflict_count(b_conflict)
`endif
  );

  typedef struct {
    logic        side;
    logic [15:0] price;
    int          pos;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor for instance A: compares each handshake against the
  // queue, then the position and valid on the following cycle.
  always begin
    @(negedge clk);
    if (rst_n && a_valid && ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_order actual side=%0d price=%0d required none", a_side, a_price);
      end else begin
        ea = qa.pop_front();
        $display("A order side=%0d price=%0d", a_side, a_price);
        check("a_side", int'(a_side), int'(ea.side));
        check("a_price", int'(a_price), int'(ea.price));
        @(negedge clk);
        check("a_pos_after", int'(a_pos), ea.pos);
        check("a_valid_after", int'(a_valid), 0);
      end
    end
  end

  always begin
    @(negedge clk);
    if (rst_n_b && b_valid && ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_order actual side=%0d price=%0d required none", b_side, b_price);
      end else begin
        eb = qb.pop_front();
        $display("B order side=%0d price=%0d", b_side, b_price);
        check("b_side", int'(b_side), int'(eb.side));
        check("b_price", int'(b_price), int'(eb.price));
        @(negedge clk);
        check("b_pos_after", int'(b_pos), eb.pos);
        check("b_valid_after", int'(b_valid), 0);
      end
    end
  end

  // One qualified sample; called just after a rising edge.
  task automatic pulse(input logic b, input logic s, input logic [15:0] p);
    dv = 1'b1; buy = b; sell = s; price = p;
    @(posedge clk); #1;
    dv = 1'b0; buy = 1'b0; sell = 1'b0;
  endtask

  // Waits for instance A to leave COOLDOWN, returning the cycles spent there.
  task automatic wait_cooldown(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_state == 2'd3) n++;
      else if (n > 0) break;
    end
    @(posedge clk); #1;
  endtask

  exp_t e;
  int n;

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0; enable = 1'b1;
    dv = 1'b0; buy = 1'b0; sell = 1'b0; ready = 1'b0; price = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_state", int'(a_state), 0);
    check("rst_valid", int'(a_valid), 0);
    check("rst_pos", int'(a_pos), 0);
    check("rst_price", int'(a_price), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Warm-up: four buys absorbed, fifth traded.
    ready = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 16'(100 + i));
    check("warm_still", int'(a_state), 0);
    pulse(1'b1, 1'b0, 16'd103);
    check("warm_done_idle", int'(a_state), 1);
    e = '{side: 1'b0, price: 16'd200, pos: 1}; qa.push_back(e);
    pulse(1'b1, 1'b0, 16'd200);
    check("accept_latency_valid", int'(a_valid), 1);
    wait_cooldown(n);
    check("cooldown_len_1", n, 16);

    // Conflict in IDLE dropped; sell during COOLDOWN dropped.
    pulse(1'b1, 1'b1, 16'd300);
    check("conflict_no_issue", int'(a_state), 1);
    e = '{side: 1'b0, price: 16'd210, pos: 2}; qa.push_back(e);
    pulse(1'b1, 1'b0, 16'd210);
    repeat (3) @(posedge clk); #1;
    pulse(1'b0, 1'b1, 16'd220);
    wait_cooldown(n);
`ifdef TRADE_STATS_EN
    check("stat_conflict", int'(a_conflict), 1);
    check("stat_dropped", int'(a_dropped), 2);
    check("stat_issued", int'(a_issued), 2);
`endif

    // Limit: position 2 blocks a buy, a sell is still accepted.
    pulse(1'b1, 1'b0, 16'd230);
    @(negedge clk);
    check("limit_pos_held", int'(a_pos), 2);
    check("limit_state_idle", int'(a_state), 1);
    @(posedge clk); #1;
    e = '{side: 1'b1, price: 16'd240, pos: 1}; qa.push_back(e);
    pulse(1'b0, 1'b1, 16'd240);
    wait_cooldown(n);
    check("cooldown_len_2", n, 16);

    // Backpressure: order held stable while enable toggles and sells arrive.
    ready = 1'b0;
    e = '{side: 1'b0, price: 16'd250, pos: 2}; qa.push_back(e);
    pulse(1'b1, 1'b0, 16'd250);
    for (int i = 0; i < 10; i++) begin
      enable = ~enable; dv = 1'b1; sell = 1'b1; price = 16'(900 + i);
      @(negedge clk);
      check("bp_hold", int'({a_state, a_valid, a_side, a_price}), int'({2'd2, 1'b1, 1'b0, 16'd250}));
      @(posedge clk); #1;
    end
    dv = 1'b0; sell = 1'b0; enable = 1'b1; ready = 1'b1;
    wait_cooldown(n);
    check("cooldown_len_bp", n, 16);

    // Asynchronous reset while an order is outstanding.
    ready = 1'b0;
    pulse(1'b0, 1'b1, 16'd260);
    check("pre_rst_valid", int'(a_valid), 1);
    repeat (3) @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(a_valid), 0);
    check("async_rst_pos", int'(a_pos), 0);
    check("async_rst_state", int'(a_state), 0);
    @(posedge clk); #1;

    // Instance B: zero cooldown, back-to-back orders.
    ready = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk); #1;
    pulse(1'b0, 1'b0, 16'd0);
    check("b_warm_idle", int'(b_state), 1);
    e = '{side: 1'b0, price: 16'd500, pos: 1}; qb.push_back(e);
    pulse(1'b1, 1'b0, 16'd500);
    check("b_valid_first", int'(b_valid), 1);
    @(posedge clk); #1;
    check("b_idle_after_hs", int'(b_state), 1);
    e = '{side: 1'b1, price: 16'd510, pos: 0}; qb.push_back(e);
    pulse(1'b0, 1'b1, 16'd510);
    check("b_back_to_back", int'({b_state, b_valid}), int'({2'd2, 1'b1}));

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/trade_order_ctrl.md
# trade_order_ctrl

Sequencing controller between the Z-score signal stage and the order-entry interface. It consumes the registered buy/sell decisions and their valid strobe, suppresses trading during statistics warm-up, and enforces a signed position limit and a post-order cooldown. It issues one order at a time over a valid/ready handshake, so the downstream order path sees at most one outstanding order.

## Interface
- `data_width`, 16: width of price samples.
- `MAX_POSITION`, 8: absolute net position limit in lots, must be ≥1.
- `COOLDOWN_CYCLES`, 16: idle cycles enforced after each accepted order; 0 is legal.
- `WARMUP_SAMPLES`, 32: valid samples discarded after reset while mean/variance settle; must be ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  trading enable; low blocks new orders only.
- `data_valid_z`  in  1  sample strobe aligned with `buy_signal`/`sell_signal`.
- `buy_signal`  in  1  Z-score buy decision.
- `sell_signal`  in  1  Z-score sell decision.
- `current_data`  in  data_width  price of the sample qualified by `data_valid_z`.
- `order_valid`  out  1  order present.
- `order_ready`  in  1  downstream accepts order.
- `order_side`  out  1  0 = buy, 1 = sell.
- `order_price`  out  data_width  latched price of the order.
- `position`  out  PW (= $clog2(MAX_POSITION)+2), signed  net filled lots.
- `ctrl_state`  out  2  current FSM state encoding.

## Operation
- States: WARMUP (0), IDLE (1), ISSUE (2), COOLDOWN (3).
- WARMUP: count `data_valid_z` pulses. The pulse that brings the count to WARMUP_SAMPLES moves the FSM to IDLE. That sample is not traded.
- IDLE: on `data_valid_z` && `enable`, the FSM accepts a sample when exactly one of buy/sell is high.
  - A buy is accepted when `position` < MAX_POSITION.
  - A sell is accepted when `position` > -MAX_POSITION.
  - On acceptance: latch side and `current_data`, then go to ISSUE.
- Signals are dropped when buy and sell are both high, when the limit blocks the order, when `enable` is low, or when they arrive in WARMUP, ISSUE or COOLDOWN. Dropped signals cause no state change and are not queued.
- ISSUE: `order_valid` stays high, and `order_side`/`order_price` stay stable, until `order_valid && order_ready`.
  - Once raised, `order_valid` is never withdrawn, even if `enable` falls.
  - On the handshake: `position` is incremented for a buy or decremented for a sell. The FSM goes to COOLDOWN, or directly to IDLE if COOLDOWN_CYCLES = 0.
- COOLDOWN: load the counter with COOLDOWN_CYCLES-1 and decrement it each cycle. When it reaches 0, go to IDLE.
- `position` saturation cannot occur by construction; the limit check guarantees |position| ≤ MAX_POSITION.

## Timing
- Reset values:
  - `order_valid`=0, `order_side`=0, `order_price`=0, `position`=0.
  - `ctrl_state`=WARMUP; warm-up and cooldown counters = 0.
- Reset takes effect immediately, including mid-ISSUE: an outstanding order is abandoned and `position` returns to 0.
- Accept latency: sample accepted at edge T, `order_valid` high after edge T, so it is visible in cycle T+1.
- Handshake at edge H: `order_valid` low, `position` updated and state changed, all visible in cycle H+1.
- `order_ready` high in the same cycle `order_valid` first rises completes the handshake at the next edge. The minimum ISSUE occupancy is 1 cycle.
- The FSM is in COOLDOWN for exactly COOLDOWN_CYCLES cycles. The earliest next acceptance is the sample at edge H+COOLDOWN_CYCLES+1.
- Inputs are assumed synchronous to `clk`; no internal synchronisers.

## Configuration
- `TRADE_STATS_EN` defined adds three outputs, all reset to 0 and wrapping on overflow:
  - `orders_issued` [31:0]: incremented at each handshake.
  - `signals_dropped` [31:0]: incremented per dropped `data_valid_z` sample with buy or sell high, outside WARMUP.
  - `conflict_count` [15:0]: incremented when buy and sell are both high.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- `trade_pkg`:
  - `ctrl_state_t` enum (WARMUP, IDLE, ISSUE, COOLDOWN).
  - `order_side_t` enum (SIDE_BUY=0, SIDE_SELL=1).
  - Helper function for position width.
- Sub-module `trade_cooldown_timer`: a loadable down-counter with a `done` output, reused for warm-up counting through separate instances or a parameterised mode.
- The FSM, limit check and output registers stay in `trade_order_ctrl`.

## Test plan
- Warm-up: WARMUP_SAMPLES=4, buy high on pulses 1–4 → no `order_valid`. Buy on pulse 5 → `order_valid`=1 next cycle, `order_side`=0, `order_price`=pulse-5 price.
- Backpressure: hold `order_ready`=0 for 10 cycles while toggling `enable` and driving new sells → order fields stable and `order_valid` held. Assert ready → `position`=+1 next cycle, then exactly 16 COOLDOWN cycles.
- Limit: MAX_POSITION=2, three buys each separated by cooldown → third dropped, `position` stays 2. A following sell is accepted → `position`=1.
- Conflict and cooldown drop: buy and sell both high in IDLE → no order. Signal during COOLDOWN → no order. With `TRADE_STATS_EN`, `conflict_count`=1 and `signals_dropped`=2.
- COOLDOWN_CYCLES=0: handshake then sell on the next cycle → accepted immediately, back-to-back orders.
- Reset during ISSUE: assert `rst_n`=0 mid-wait → `order_valid`=0, `position`=0, state WARMUP in the same cycle (async).
